// File: rtl/sudoku_pkg.sv
// Shared definitions for the sudoku solve sequencer.
//   - board geometry: 81 cells of 4 bits packed into a 324-bit word,
//     cell k = 9*row + col at bits [4k+3:4k], 0 = empty
//   - engine ids, pass limit, watchdog limit
//   - sequencer FSM state encoding
package sudoku_pkg;

    localparam int NUM_CELLS = 81;
    localparam int CELL_W    = 4;
    localparam int GRID_W    = NUM_CELLS * CELL_W;

    localparam logic ENG_SINGLES = 1'b0;
    localparam logic ENG_PAIRS   = 1'b1;

    localparam int MAX_PASSES = 200;
    localparam int WD_LIMIT   = 4095;

    typedef enum logic [2:0] {
        IDLE,
        RUN_S,
        WAIT_S,
        RUN_P,
        WAIT_P,
        CHECK,
        SOLVED,
        STUCK
    } state_t;

    // SOLVED and STUCK both expose the board through the readout port.
    function automatic logic is_readout(input state_t s);
        return (s == SOLVED) || (s == STUCK);
    endfunction

endpackage

// File: rtl/cell_index_to_rc.sv
// Converts a linear cell index (0..80) to a 1-based row and column.
// Ports:
//   idx  in  7  linear cell index, 9*row + col
//   row  out 4  idx / 9 + 1   (1..9)
//   col  out 4  idx mod 9 + 1 (1..9)
module cell_index_to_rc (
    input  logic [6:0] idx,
    output logic [3:0] row,
    output logic [3:0] col
);

    // Division by a constant; the quotient and remainder both fit in 4 bits
    // for any index inside the board, so truncation is safe.
    assign row = 4'(idx / 7'd9) + 4'd1;
    assign col = 4'(idx % 7'd9) + 4'd1;

endmodule

// File: rtl/solve_sequencer.sv
// Sequences the sudoku strategy engines (naked singles, naked pairs) until the
// board is full or no further progress is possible, then offers a stepped
// cell-by-cell readout of the board.
// Ports:
//   clk, reset    clock; synchronous active-high reset
//   start         pulse, starts a solve from IDLE/SOLVED/STUCK
//   next          level, each rising edge advances the readout index
//   grid_in       current board from the engines (324 bits, 0 = empty cell)
//   eng_done      pulse from the engine at the end of its pass
//   eng_changed   sampled with eng_done, 1 = the pass modified the board
//   eng_sel       engine select, 0 = singles, 1 = pairs
//   eng_start     one-cycle pulse launching the selected engine
//   D1, D2, D3    readout row (1..9), column (1..9), cell value (0..9)
//   alldone       board solved (registered)
//   stuck         no progress / pass limit / watchdog (registered)
//   busy          FSM is in a RUN or WAIT state
//
// Engine handshake: eng_start is a single-cycle request qualified by eng_sel;
// eng_sel holds from the RUN cycle until the eng_done cycle. The engine
// answers with exactly one eng_done pulse carrying eng_changed; eng_done is
// only accepted in WAIT_S/WAIT_P, anywhere else it is dropped.
module solve_sequencer
    import sudoku_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              next,
    input  logic [GRID_W-1:0] grid_in,
    input  logic              eng_done,
    input  logic              eng_changed,
    output logic              eng_sel,
    output logic              eng_start,
    output logic [3:0]        D1,
    output logic [3:0]        D2,
    output logic [3:0]        D3,
    output logic              alldone,
    output logic              stuck,
    output logic              busy
);

    state_t      state;
    state_t      state_d;

    logic [7:0]  pass_cnt;
    logic [11:0] wd_cnt;
    logic        changed_q;
    logic        last_eng_q;
    logic [6:0]  idx;
    logic [6:0]  idx_d;
    logic        next_q;
    logic        next_rise;
    logic        alldone_q;
    logic        stuck_q;
    logic [3:0]  d1_q;
    logic [3:0]  d2_q;
    logic [3:0]  d3_q;

    logic        in_wait;
    logic        start_hit;
    logic        done_hit;
    logic        all_filled;
    logic [NUM_CELLS-1:0] cell_nz;
    logic [3:0]  rd_row;
    logic [3:0]  rd_col;
    logic [3:0]  rd_val;

    // ------------------------------------------------------------------
    // Board full check: one nonzero flag per cell, reduced over 81 cells.
    // ------------------------------------------------------------------
    for (genvar k = 0; k < NUM_CELLS; k++) begin : g_cell_nz
        assign cell_nz[k] = |grid_in[k*CELL_W +: CELL_W];
    end
    assign all_filled = &cell_nz;

    assign in_wait   = (state == WAIT_S) || (state == WAIT_P);
    assign start_hit = start && ((state == IDLE) || is_readout(state));
    assign done_hit  = in_wait && eng_done;
    assign next_rise = next && !next_q;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state;
        case (state)
            IDLE, SOLVED, STUCK: begin
                if (start) state_d = RUN_S;
            end
            RUN_S: state_d = WAIT_S;
            RUN_P: state_d = WAIT_P;
            WAIT_S, WAIT_P: begin
                // A done arriving on the watchdog's last cycle still counts.
                if (eng_done)                            state_d = CHECK;
                else if (wd_cnt == 12'(WD_LIMIT - 1))    state_d = STUCK;
            end
            CHECK: begin
                if (all_filled)                          state_d = SOLVED;
                else if (pass_cnt == 8'(MAX_PASSES))     state_d = STUCK;
                else if (changed_q)                      state_d = RUN_S;
                else if (last_eng_q == ENG_SINGLES)      state_d = RUN_P;
                else                                     state_d = STUCK;
            end
            default: state_d = IDLE;
        endcase
    end

    // Readout index: zero on entry to SOLVED/STUCK, steps on each next edge,
    // held at zero everywhere else.
    always_comb begin
        idx_d = idx;
        if (!is_readout(state_d) || !is_readout(state)) begin
            idx_d = '0;
        end else if (next_rise) begin
            idx_d = (idx == 7'(NUM_CELLS - 1)) ? 7'd0 : idx + 7'd1;
        end
    end

    cell_index_to_rc u_rc (
        .idx (idx_d),
        .row (rd_row),
        .col (rd_col)
    );

    assign rd_val = grid_in[{idx_d, 2'b00} +: CELL_W];

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            pass_cnt   <= '0;
            wd_cnt     <= '0;
            changed_q  <= 1'b0;
            last_eng_q <= ENG_SINGLES;
            idx        <= '0;
            alldone_q  <= 1'b0;
            stuck_q    <= 1'b0;
            d1_q       <= '0;
            d2_q       <= '0;
            d3_q       <= '0;
        end else begin
            state <= state_d;

            if (start_hit) begin
                pass_cnt   <= '0;
                changed_q  <= 1'b0;
                last_eng_q <= ENG_SINGLES;
            end else if (done_hit) begin
                pass_cnt   <= pass_cnt + 8'd1;
                changed_q  <= eng_changed;
                last_eng_q <= eng_sel;
            end

            // RUN always precedes WAIT, so the count starts at zero on entry.
            wd_cnt <= in_wait ? wd_cnt + 12'd1 : 12'd0;

            idx       <= idx_d;
            alldone_q <= (state_d == SOLVED);
            stuck_q   <= (state_d == STUCK);

            if (is_readout(state_d)) begin
                d1_q <= rd_row;
                d2_q <= rd_col;
                d3_q <= rd_val;
            end else begin
                d1_q <= '0;
                d2_q <= '0;
                d3_q <= '0;
            end
        end
    end

    // The edge detector samples every cycle, through reset as well, so a
    // level already high when the readout opens never counts as an edge.
    always_ff @(posedge clk) begin
        next_q <= next;
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign eng_start = (state == RUN_S) || (state == RUN_P);
    assign eng_sel   = ((state == RUN_P) || (state == WAIT_P)) ? ENG_PAIRS : ENG_SINGLES;
    assign busy      = (state == RUN_S) || (state == WAIT_S) ||
                       (state == RUN_P) || (state == WAIT_P);
    assign alldone   = alldone_q;
    assign stuck     = stuck_q;
    assign D1        = d1_q;
    assign D2        = d2_q;
    assign D3        = d3_q;

endmodule

// File: tb/tb_solve_sequencer.sv
module tb_solve_sequencer;
  import sudoku_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset, start, next, eng_done, eng_changed;
  logic [GRID_W-1:0] grid_in;
  logic eng_sel, eng_start, alldone, stuck, busy;
  logic [3:0] D1, D2, D3;

  always #5 clk = ~clk;

  solve_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .next(next), .grid_in(grid_in),
    .eng_done(eng_done), .eng_changed(eng_changed), .eng_sel(eng_sel),
    .eng_start(eng_start), .D1(D1), .D2(D2), .D3(D3), .alldone(alldone),
    .stuck(stuck), .busy(busy)
  );

  // ---------------- scoreboard state ----------------
  int n_total = 0;
  int n_pass  = 0;
  logic [0:0] exp_q[$];          // expected eng_sel per pass
  bit   ch_script[1:256];        // eng_changed returned on pass p
  int   fill_pass;               // pass at which the board becomes full (0 = never)
  logic [GRID_W-1:0] grid_full, grid_holes;
  logic [6:0] rd_idx;            // model readout index

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // ---------------- reference model ----------------
  // Walks the solving rules pass by pass: a productive pass goes back to
  // singles, an unproductive singles pass tries pairs, an unproductive pairs
  // pass gives up; a full board wins, pass 200 gives up.
  task automatic model_solve(output bit solved, output int npass);
    logic [0:0] sel;
    sel = 1'b0;
    solved = 1'b0;
    npass = 0;
    exp_q.delete();
    for (int p = 1; p <= MAX_PASSES; p++) begin
      exp_q.push_back(sel);
      npass = p;
      if (p == fill_pass) begin solved = 1'b1; break; end
      if (p == MAX_PASSES) break;
      if (ch_script[p]) sel = 1'b0;
      else if (sel == 1'b0) sel = 1'b1;
      else break;
    end
  endtask

  task automatic make_grids();
    int z;
    for (int k = 0; k < NUM_CELLS; k++) begin
      grid_full[k*4 +: 4] = 4'($urandom_range(1, 9));
    end
    grid_holes = grid_full;
    z = $urandom_range(0, NUM_CELLS - 1);
    grid_holes[z*4 +: 4] = 4'd0;
    for (int k = 0; k < NUM_CELLS; k++) begin
      if ($urandom_range(0, 3) == 0) grid_holes[k*4 +: 4] = 4'd0;
    end
  endtask

  // ---------------- driver: one complete solve ----------------
  task automatic run_solve(input string tag, input int busy_start_pass, input int max_lat);
    bit solved;
    int npass, lat;
    logic [0:0] sel_exp;
    model_solve(solved, npass);
    grid_in = grid_holes;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_total++;
    if ({eng_start, busy, alldone, stuck, D1, D2, D3} !== {4'b1100, 12'h000})
      $display("FAIL %s start_entry: got %b_%h%h%h, expected 1100_000", tag,
               {eng_start, busy, alldone, stuck}, D1, D2, D3);
    else n_pass++;
    for (int p = 1; p <= npass; p++) begin
      sel_exp = exp_q.pop_front();
      n_total++;
      if (eng_sel !== sel_exp)
        $display("FAIL %s eng_sel pass %0d: got %b, expected %b", tag, p, eng_sel, sel_exp);
      else n_pass++;
      tick();
      n_total++;
      if ({eng_start, busy, eng_sel} !== {2'b01, sel_exp})
        $display("FAIL %s wait_entry pass %0d: got %b, expected %b", tag, p,
                 {eng_start, busy, eng_sel}, {2'b01, sel_exp});
      else n_pass++;
      lat = $urandom_range(0, max_lat);
      if (p == busy_start_pass && lat == 0) lat = 1;
      for (int i = 0; i < lat; i++) begin
        if (p == busy_start_pass && i == 0) start = 1'b1;
        tick();
        start = 1'b0;
        n_total++;
        if ({eng_start, busy, eng_sel} !== {2'b01, sel_exp})
          $display("FAIL %s wait_hold pass %0d: got %b, expected %b", tag, p,
                   {eng_start, busy, eng_sel}, {2'b01, sel_exp});
        else n_pass++;
      end
      eng_done = 1'b1;
      eng_changed = ch_script[p];
      if (p == fill_pass) grid_in = grid_full;
      tick();
      eng_done = 1'b0;
      eng_changed = 1'b0;
      n_total++;
      if ({eng_start, busy, alldone, stuck} !== 4'b0000)
        $display("FAIL %s check_cycle pass %0d: got %b, expected 0000", tag, p,
                 {eng_start, busy, alldone, stuck});
      else n_pass++;
      tick();
      if (p < npass) begin
        n_total++;
        if ({eng_start, busy, alldone, stuck} !== 4'b1100)
          $display("FAIL %s rerun pass %0d: got %b, expected 1100", tag, p,
                   {eng_start, busy, alldone, stuck});
        else n_pass++;
      end else begin
        n_total++;
        if ({eng_start, busy, alldone, stuck} !== {2'b00, solved, !solved})
          $display("FAIL %s outcome: got %b, expected %b", tag,
                   {eng_start, busy, alldone, stuck}, {2'b00, solved, !solved});
        else n_pass++;
        n_total++;
        if ({D1, D2, D3} !== {4'd1, 4'd1, grid_in[3:0]})
          $display("FAIL %s readout_entry: got %h%h%h, expected 11%h", tag, D1, D2, D3, grid_in[3:0]);
        else n_pass++;
      end
    end
    rd_idx = 7'd0;
  endtask

  // ---------------- driver: readout stepping ----------------
  task automatic step_readout(input string tag, input int n);
    logic [3:0] er, ec, ev;
    for (int i = 0; i < n; i++) begin
      next = 1'b1;
      tick();
      rd_idx = (rd_idx == 7'd80) ? 7'd0 : rd_idx + 7'd1;
      er = 4'(rd_idx / 7'd9) + 4'd1;
      ec = 4'(rd_idx % 7'd9) + 4'd1;
      ev = grid_in[{rd_idx, 2'b00} +: 4];
      n_total++;
      if ({D1, D2, D3} !== {er, ec, ev})
        $display("FAIL %s step %0d: got %h%h%h, expected %h%h%h", tag, i, D1, D2, D3, er, ec, ev);
      else n_pass++;
      next = 1'b0;
      repeat ($urandom_range(1, 2)) tick();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; start = 1'b1; next = 1'b1; eng_done = 1'b1; eng_changed = 1'b1;
    grid_in = '0;
    repeat (3) tick();
    n_total++;
    if ({eng_start, eng_sel, busy, alldone, stuck, D1, D2, D3} !== 17'h0)
      $display("FAIL reset_outputs: got %h, expected 0",
               {eng_start, eng_sel, busy, alldone, stuck, D1, D2, D3});
    else n_pass++;
    reset = 1'b0; start = 1'b0; next = 1'b0; eng_done = 1'b0; eng_changed = 1'b0;
    repeat (2) tick();
    n_total++;
    if ({eng_start, busy, alldone, stuck} !== 4'b0000)
      $display("FAIL reset_idle: got %b, expected 0000", {eng_start, busy, alldone, stuck});
    else n_pass++;
  endtask

  task automatic test_singles_solve();
    make_grids();
    ch_script[1] = 1'b1; ch_script[2] = 1'b1; ch_script[3] = 1'b0;
    fill_pass = 3;
    run_solve("singles_solve", 0, 3);
  endtask

  task automatic test_readout_wrap();
    step_readout("readout_wrap", 81);
    n_total++;
    if ({D1, D2, D3} !== {4'd1, 4'd1, grid_in[3:0]})
      $display("FAIL readout_wrapped: got %h%h%h, expected 11%h", D1, D2, D3, grid_in[3:0]);
    else n_pass++;
    next = 1'b1;
    repeat (50) tick();
    n_total++;
    if ({D1, D2, D3} !== {4'd1, 4'd2, grid_in[7:4]})
      $display("FAIL readout_held: got %h%h%h, expected 12%h", D1, D2, D3, grid_in[7:4]);
    else n_pass++;
    next = 1'b0;
    repeat (2) tick();
    n_total++;
    if ({D1, D2} !== {4'd1, 4'd2})
      $display("FAIL readout_release: got %h%h, expected 12", D1, D2);
    else n_pass++;
  endtask

  task automatic test_next_high_on_entry();
    make_grids();
    ch_script[1] = 1'b1; ch_script[2] = 1'b0;
    fill_pass = 2;
    next = 1'b1;
    run_solve("next_high", 0, 2);
    repeat (3) tick();
    n_total++;
    if ({D1, D2, alldone} !== {4'd1, 4'd1, 1'b1})
      $display("FAIL next_high_entry: got %h%h%b, expected 111", D1, D2, alldone);
    else n_pass++;
    next = 1'b0;
    tick();
    step_readout("next_high_after", 2);
  endtask

  task automatic test_pairs_stuck();
    make_grids();
    ch_script[1] = 1'b0; ch_script[2] = 1'b1; ch_script[3] = 1'b0; ch_script[4] = 1'b0;
    fill_pass = 0;
    run_solve("pairs_stuck", 0, 3);
    step_readout("stuck_readout", 12);
  endtask

  task automatic test_random_runs();
    for (int r = 0; r < 8; r++) begin
      make_grids();
      for (int p = 1; p <= 256; p++) ch_script[p] = 1'($urandom_range(0, 1));
      fill_pass = $urandom_range(0, 10);
      run_solve($sformatf("random_%0d", r), 0, 3);
      step_readout($sformatf("random_rd_%0d", r), $urandom_range(0, 5));
    end
  endtask

  task automatic test_reset_mid_wait();
    make_grids();
    grid_in = grid_holes;
    start = 1'b1; tick(); start = 1'b0;   // RUN_S
    tick();                               // WAIT_S
    eng_done = 1'b1; eng_changed = 1'b0;
    tick();                               // CHECK
    eng_done = 1'b0;
    tick();                               // RUN_P
    n_total++;
    if ({eng_start, eng_sel} !== 2'b11)
      $display("FAIL rmw_run_p: got %b, expected 11", {eng_start, eng_sel});
    else n_pass++;
    tick();                               // WAIT_P
    tick();
    reset = 1'b1; eng_done = 1'b1; eng_changed = 1'b1; start = 1'b1; next = 1'b1;
    tick();
    n_total++;
    if ({eng_start, eng_sel, busy, alldone, stuck, D1, D2, D3} !== 17'h0)
      $display("FAIL rmw_reset: got %h, expected 0",
               {eng_start, eng_sel, busy, alldone, stuck, D1, D2, D3});
    else n_pass++;
    reset = 1'b0; eng_done = 1'b0; eng_changed = 1'b0; start = 1'b0; next = 1'b0;
    tick();
    eng_done = 1'b1; eng_changed = 1'b1;  // late done from the abandoned pass
    tick();
    eng_done = 1'b0; eng_changed = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++;
      if ({eng_start, busy, alldone, stuck, D1, D2, D3} !== 16'h0)
        $display("FAIL rmw_late_done %0d: got %h, expected 0", i,
                 {eng_start, busy, alldone, stuck, D1, D2, D3});
      else n_pass++;
    end
  endtask

  task automatic test_watchdog();
    make_grids();
    grid_in = grid_holes;
    start = 1'b1; tick(); start = 1'b0;   // RUN_S
    tick();                               // WAIT_S entered: cycle 0
    repeat (WD_LIMIT - 1) tick();
    n_total++;
    if ({busy, stuck} !== 2'b10)
      $display("FAIL watchdog_early: got %b, expected 10", {busy, stuck});
    else n_pass++;
    tick();
    n_total++;
    if ({busy, stuck, alldone} !== 3'b010)
      $display("FAIL watchdog_fire: got %b, expected 010", {busy, stuck, alldone});
    else n_pass++;
    eng_done = 1'b1; eng_changed = 1'b1;
    tick();
    eng_done = 1'b0; eng_changed = 1'b0;
    tick();
    n_total++;
    if ({eng_start, busy, stuck} !== 3'b001)
      $display("FAIL watchdog_late_done: got %b, expected 001", {eng_start, busy, stuck});
    else n_pass++;
  endtask

  task automatic test_pass_limit();
    make_grids();
    for (int p = 1; p <= 256; p++) ch_script[p] = 1'b1;
    fill_pass = 0;
    run_solve("pass_limit", 10, 1);
  endtask

  initial begin
    test_reset();
    test_singles_solve();
    test_readout_wrap();
    test_next_high_on_entry();
    test_pairs_stuck();
    test_random_runs();
    test_reset_mid_wait();
    test_watchdog();
    test_pass_limit();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
